sram_access_arbiter: RTL

//  Shares the single 1Mx16 external SRAM between two requesters.

---
 rtl/sram_access_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sram_access_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sram_access_arbiter                                            |
// | Brief   : Two-port arbiter and strobe sequencer for a 1Mx16 async SRAM.  |
// |           Optional macro SRAM_ARB_FIXED_PRI_EN selects fixed priority.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sram_access_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int AW            = 20,
    parameter int DW            = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          CE,
    output logic          UB,
    output logic          LB,
    output logic          OE,
    output logic          WE,
    output logic [AW-1:0] ADDR,
    output logic [DW-1:0] Data_to_SRAM,
    input  logic [DW-1:0] Data_from_SRAM,
    output logic          Data_OE
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCESS  = 2'd1;
    localparam logic [1:0] S_RECOVER = 2'd2;

    localparam logic [3:0] c_reload = 4'(ACCESS_CYCLES - 1);

    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic       r_grant;
    logic       r_we;
    logic       w_any_req;
    logic       w_pick1;
    logic       w_we;

`ifdef SRAM_ARB_FIXED_PRI_EN
    assign w_pick1 = req1 & ~req0;
`else
    logic r_last_grant;
    // Port 1 wins a tie only when port 0 was served last.
    assign w_pick1 = req1 & (~req0 | ~r_last_grant);
`endif

    assign w_any_req = req0 | req1;
    assign w_we      = w_pick1 ? we1 : we0;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_grant      <= 1'b0;
            r_we         <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRI_EN
            r_last_grant <= 1'b1;
`endif
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            busy         <= 1'b0;
            rdata        <= '0;
            CE           <= 1'b1;
            UB           <= 1'b1;
            LB           <= 1'b1;
            OE           <= 1'b1;
            WE           <= 1'b1;
            ADDR         <= '0;
            Data_to_SRAM <= '0;
            Data_OE      <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state      <= S_ACCESS;
                        r_cnt        <= c_reload;
                        r_grant      <= w_pick1;
                        r_we         <= w_we;
`ifndef SRAM_ARB_FIXED_PRI_EN
                        r_last_grant <= w_pick1;
`endif
                        busy         <= 1'b1;
                        ADDR         <= w_pick1 ? addr1 : addr0;
                        Data_to_SRAM <= w_pick1 ? wdata1 : wdata0;
                        CE           <= 1'b0;
                        UB           <= 1'b0;
                        LB           <= 1'b0;
                        OE           <= w_we;
                        WE           <= ~w_we;
                        Data_OE      <= w_we;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RECOVER;
                        CE      <= 1'b1;
                        UB      <= 1'b1;
                        LB      <= 1'b1;
                        OE      <= 1'b1;
                        WE      <= 1'b1;
                        Data_OE <= 1'b0;
                        ack0    <= ~r_grant;
                        ack1    <= r_grant;
                        // Read data is captured on the final edge of the strobe window.
                        if (!r_we) begin
                            rdata <= Data_from_SRAM;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RECOVER: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
